// File: rtl/mu0_control_if.sv
// Control/status bundle between the MU0 controller and its datapath and memory.
// Signal names keep the legacy port names so existing datapath wiring maps one-to-one.
interface mu0_control_if;
  logic [3:0] F;
  logic       N;
  logic       Z;
  logic       MEM_ready;
  logic       Addr_sel;
  logic       X_sel;
  logic       Y_sel;
  logic [1:0] ALU_fs;
  logic       Acc_ce;
  logic       PC_ce;
  logic       IR_ce;
  logic       Acc_oe;
  logic       MEM_rd;
  logic       MEM_wr;
  logic       Halted;
  logic       Fault;

  modport master (
    input  F, N, Z, MEM_ready,
    output Addr_sel, X_sel, Y_sel, ALU_fs, Acc_ce, PC_ce, IR_ce, Acc_oe,
           MEM_rd, MEM_wr, Halted, Fault
  );

  modport slave (
    output F, N, Z, MEM_ready,
    input  Addr_sel, X_sel, Y_sel, ALU_fs, Acc_ce, PC_ce, IR_ce, Acc_oe,
           MEM_rd, MEM_wr, Halted, Fault
  );
endinterface

// File: rtl/mu0_control.sv
// MU0 fetch/execute controller: Mealy FSM driving datapath selects, register
// enables and memory requests, with a bounded memory-wait timeout to FAULT.
module mu0_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          nReset,
  mu0_control_if.master bus
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [3:0] TIMEOUT_C = TIMEOUT[3:0];

  logic [1:0] state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       ready;
  logic       timed_out;
  logic       addr_sel, x_sel, y_sel;
  logic [1:0] alu_fs;
  logic       acc_ce, pc_ce, ir_ce, acc_oe;
  logic       mem_rd, mem_wr, halted, fault;

  // Gating ready with reset makes the reset-time outputs the FETCH/not-ready values.
  assign ready     = bus.MEM_ready & nReset;
  assign timed_out = (wait_q == TIMEOUT_C) && !ready;

  always_comb begin
    addr_sel = 1'b0;
    x_sel    = 1'b0;
    y_sel    = 1'b0;
    alu_fs   = 2'b00;
    acc_ce   = 1'b0;
    pc_ce    = 1'b0;
    ir_ce    = 1'b0;
    acc_oe   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      FETCH: begin
        mem_rd = 1'b1;
        x_sel  = 1'b1;
        alu_fs = 2'b10;
        ir_ce  = ready;
        pc_ce  = ready;
        if (ready)          state_d = EXEC;
        else if (timed_out) state_d = FAULT;
      end
      EXEC: begin
        unique case (bus.F)
          4'd0: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            acc_ce   = ready;
          end
          4'd1: begin
            addr_sel = 1'b1;
            mem_wr   = 1'b1;
            acc_oe   = 1'b1;
          end
          4'd2, 4'd3: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            alu_fs   = (bus.F == 4'd3) ? 2'b11 : 2'b01;
            acc_ce   = ready;
          end
          4'd4, 4'd5, 4'd6: begin
            y_sel   = 1'b1;
            pc_ce   = (bus.F == 4'd4) ? 1'b1 :
                      (bus.F == 4'd5) ? ~bus.N : ~bus.Z;
            state_d = FETCH;
          end
          4'd7:    state_d = HALT;
          default: state_d = FAULT;
        endcase
        if (bus.F < 4'd4) begin
          if (ready)          state_d = FETCH;
          else if (timed_out) state_d = FAULT;
        end
      end
      HALT:    halted = 1'b1;
      default: fault  = 1'b1;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q || ready) wait_d = '0;
    else if (mem_rd || mem_wr)       wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.Addr_sel = addr_sel;
  assign bus.X_sel    = x_sel;
  assign bus.Y_sel    = y_sel;
  assign bus.ALU_fs   = alu_fs;
  assign bus.Acc_ce   = acc_ce;
  assign bus.PC_ce    = pc_ce;
  assign bus.IR_ce    = ir_ce;
  assign bus.Acc_oe   = acc_oe;
  assign bus.MEM_rd   = mem_rd;
  assign bus.MEM_wr   = mem_wr;
  assign bus.Halted   = halted;
  assign bus.Fault    = fault;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: directed scenarios plus randomized
// instruction/ready streams compared against an instruction-level reference model.
module tb_mu0_control;

  localparam int TO    = 15;
  localparam int S_F   = 0;
  localparam int S_E   = 1;
  localparam int S_H   = 2;
  localparam int S_X   = 3;

  logic Clk = 1'b0;
  logic nReset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mst = S_F;
  int   mwait = 0;

  mu0_control_if bus ();

  mu0_control #(.TIMEOUT(TO)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {Addr_sel,X_sel,Y_sel,ALU_fs,Acc_ce,PC_ce,IR_ce,Acc_oe,MEM_rd,MEM_wr,Halted,Fault}
  function automatic logic [12:0] dut_out();
    return {bus.Addr_sel, bus.X_sel, bus.Y_sel, bus.ALU_fs, bus.Acc_ce, bus.PC_ce,
            bus.IR_ce, bus.Acc_oe, bus.MEM_rd, bus.MEM_wr, bus.Halted, bus.Fault};
  endfunction

  function automatic logic [12:0] exp_out(input int st, input logic [3:0] f,
                                          input logic n, input logic z, input logic rdy);
    logic as, xs, ys, ace, pce, ice, aoe, rd, wr, h, flt;
    logic [1:0] fs;
    {as, xs, ys, ace, pce, ice, aoe, rd, wr, h, flt} = '0;
    fs = 2'b00;
    if (st == S_F) begin
      xs = 1; fs = 2'b10; rd = 1; ice = rdy; pce = rdy;
    end else if (st == S_E) begin
      if (f == 0) begin
        as = 1; rd = 1; ace = rdy;
      end else if (f == 1) begin
        as = 1; wr = 1; aoe = 1;
      end else if (f == 2 || f == 3) begin
        as = 1; rd = 1; fs = (f == 2) ? 2'b01 : 2'b11; ace = rdy;
      end else if (f >= 4 && f <= 6) begin
        ys = 1;
        if (f == 4)      pce = 1;
        else if (f == 5) pce = !n;
        else             pce = !z;
      end
    end else if (st == S_H) begin
      h = 1;
    end else begin
      flt = 1;
    end
    return {as, xs, ys, fs, ace, pce, ice, aoe, rd, wr, h, flt};
  endfunction

  function automatic bit is_access(input int st, input logic [3:0] f);
    return (st == S_F) || (st == S_E && f < 4);
  endfunction

  function automatic int exp_next(input int st, input int w, input logic [3:0] f, input logic rdy);
    if (is_access(st, f)) begin
      if (rdy)     return (st == S_F) ? S_E : S_F;
      if (w == TO) return S_X;
      return st;
    end
    if (st == S_E) return (f < 7) ? S_F : ((f == 7) ? S_H : S_X);
    return st;
  endfunction

  int nxt_st, nxt_w;

  // Called at posedge+1: apply inputs, check outputs mid-cycle, precompute model step.
  task automatic drive(input logic [3:0] f, input logic n, input logic z, input logic rdy);
    bus.F = f; bus.N = n; bus.Z = z; bus.MEM_ready = rdy;
    #3;
    check_eq("outputs", {19'd0, dut_out()}, {19'd0, exp_out(mst, f, n, z, rdy)});
    nxt_st = exp_next(mst, mwait, f, rdy);
    if (nxt_st != mst || rdy)       nxt_w = 0;
    else if (is_access(mst, f))     nxt_w = mwait + 1;
    else                            nxt_w = mwait;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    mst   = nxt_st;
    mwait = nxt_w;
  endtask

  task automatic hit_reset();
    nReset = 1'b0;
    bus.MEM_ready = 1'($urandom);
    bus.F = 4'($urandom);
    #1;
    check_eq("reset_out", {19'd0, dut_out()}, {19'd0, exp_out(S_F, bus.F, bus.N, bus.Z, 1'b0)});
    mst = S_F;
    mwait = 0;
    @(posedge Clk);
    #1;
    check_eq("reset_hold", {19'd0, dut_out()}, {19'd0, 13'b0_1_0_10_0000_1_0_0_0});
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0;
    bus.F = '0; bus.N = 0; bus.Z = 0; bus.MEM_ready = 0;
    #2;
    check_eq("por_out", {19'd0, dut_out()}, {19'd0, 13'b0_1_0_10_0000_1_0_0_0});
    @(posedge Clk);
    #1;
    nReset = 1'b1;

    // LDA with zero-wait memory: two clocks per instruction
    for (int i = 0; i < 2; i++) begin
      drive(4'd0, 0, 0, 1);
      check_eq("lda_fetch_ce", {30'd0, bus.IR_ce, bus.PC_ce}, 32'd3);
      tick();
      drive(4'd0, 0, 0, 1);
      check_eq("lda_exec", {30'd0, bus.Addr_sel, bus.Acc_ce}, 32'd3);
      tick();
    end

    // JGE against N, JNE against Z
    for (int i = 0; i < 4; i++) begin
      logic [3:0] f;
      logic flag;
      f    = (i < 2) ? 4'd5 : 4'd6;
      flag = (i % 2 == 0);
      drive(f, 0, 0, 1);
      tick();
      drive(f, (f == 5) ? flag : 1'b0, (f == 6) ? flag : 1'b0, 1'b0);
      check_eq("jump_pc_ce", {31'd0, bus.PC_ce}, {31'd0, !flag});
      check_eq("jump_sel", {29'd0, bus.Y_sel, bus.ALU_fs}, 32'd4);
      tick();
    end

    // STA with three wait cycles
    drive(4'd1, 0, 0, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(4'd1, 0, 0, (i == 3));
      check_eq("sta_wr_oe", {30'd0, bus.MEM_wr, bus.Acc_oe}, 32'd3);
      check_eq("sta_no_ce", {29'd0, bus.Acc_ce, bus.PC_ce, bus.IR_ce}, 32'd0);
      tick();
    end
    drive(4'd0, 0, 0, 0);
    check_eq("sta_back_fetch", {31'd0, bus.MEM_rd}, 32'd1);
    tick();

    // Fetch timeout: TIMEOUT+1 not-ready cycles lead to FAULT
    hit_reset();
    for (int i = 0; i <= TO; i++) begin
      drive(4'd0, 0, 0, 0);
      tick();
    end
    drive(4'd0, 0, 0, 1);
    check_eq("timeout_fault", {31'd0, bus.Fault}, 32'd1);
    tick();

    // Ready on the timeout cycle completes the fetch
    hit_reset();
    for (int i = 0; i <= TO; i++) begin
      drive(4'd2, 0, 0, (i == TO));
      tick();
    end
    drive(4'd2, 0, 0, 0);
    check_eq("late_ready_exec", {30'd0, bus.Addr_sel, bus.Fault}, 32'd2);
    tick();

    // STP, then asynchronous mid-cycle reset
    hit_reset();
    drive(4'd7, 0, 0, 1);
    tick();
    drive(4'd7, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(4'($urandom), 1'($urandom), 1'($urandom), 1'(i));
      check_eq("halted_sticky", {31'd0, bus.Halted}, 32'd1);
      tick();
    end
    #2;
    nReset = 1'b0;
    #1;
    check_eq("async_reset_rd", {30'd0, bus.MEM_rd, bus.Halted}, 32'd2);
    hit_reset();

    // Illegal opcode
    drive(4'd9, 0, 0, 1);
    tick();
    drive(4'd9, 0, 0, 1);
    tick();
    drive(4'd0, 0, 0, 1);
    check_eq("illegal_fault", {31'd0, bus.Fault}, 32'd1);
    tick();
    hit_reset();

    // Randomized segments with varying memory latency
    for (int seg = 0; seg < 40; seg++) begin
      int pct;
      pct = (seg % 3 == 0) ? 95 : ((seg % 3 == 1) ? 60 : 4);
      for (int c = 0; c < 30; c++) begin
        logic [3:0] f;
        f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        drive(f, 1'($urandom), 1'($urandom), ($urandom_range(0, 99) < pct));
        if ($urandom_range(0, 49) == 0) begin
          #1;
          nReset = 1'b0;
          #1;
          check_eq("rand_async_reset", {19'd0, dut_out()},
                   {19'd0, exp_out(S_F, bus.F, bus.N, bus.Z, 1'b0)});
          hit_reset();
        end else begin
          tick();
        end
      end
      if (mst == S_H || mst == S_X) hit_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 Parameter TIMEOUT, default 15, the number of consecutive cycles a memory access may wait for MEM_ready before FAULT; legal range 1..15.
REQ-002 Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 F  input  4  opcode, taken from IR[15:12].
REQ-005 N  input  1  accumulator negative flag (Acc[15]).
REQ-006 Z  input  1  accumulator zero flag (Acc == 0).
REQ-007 MEM_ready  input  1  memory completes the current access in this cycle.
REQ-008 Addr_sel  output  1  address mux select: 0 = PC, 1 = IR[11:0].
REQ-009 X_sel  output  1  ALU X mux select: 0 = Acc, 1 = PC.
REQ-010 Y_sel  output  1  ALU Y mux select: 0 = memory data, 1 = IR[11:0].
REQ-011 ALU_fs  output  2  ALU function: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X-Y.
REQ-012 Acc_ce, PC_ce, IR_ce  output  1 each  register load enables.
REQ-013 Acc_oe  output  1  drives Acc onto the write-data bus.
REQ-014 MEM_rd, MEM_wr  output  1 each  memory read and write requests.
REQ-015 Halted, Fault  output  1 each  status flags.

Function
REQ-016 The block SHALL be an FSM with four states: FETCH, EXEC, HALT and FAULT.
REQ-017 All outputs SHALL be combinational from state, F, N, Z and MEM_ready (Mealy).
REQ-018 Select and ALU_fs values SHALL be 0 in any state or opcode that does not specify them.
REQ-019 FETCH: Addr_sel=0, MEM_rd=1, X_sel=1, ALU_fs=10; IR_ce=PC_ce=MEM_ready.
REQ-020 FETCH SHALL go to EXEC on MEM_ready=1 and otherwise stay in FETCH.
REQ-021 EXEC, F=0 (LDA): Addr_sel=1, MEM_rd=1, Y_sel=0, ALU_fs=00, Acc_ce=MEM_ready.
REQ-022 EXEC, F=1 (STA): Addr_sel=1, MEM_wr=1, Acc_oe=1; no register enable.
REQ-023 EXEC, F=2 (ADD): Addr_sel=1, MEM_rd=1, X_sel=0, Y_sel=0, ALU_fs=01, Acc_ce=MEM_ready.
REQ-024 EXEC, F=3 (SUB): identical to ADD except ALU_fs=11.
REQ-025 For F=0..3, EXEC SHALL go to FETCH on MEM_ready=1 and otherwise stay in EXEC.
REQ-026 EXEC, F=4/5/6 (JMP/JGE/JNE): Y_sel=1, ALU_fs=00, no memory request, MEM_ready ignored, always go to FETCH next cycle.
REQ-027 PC_ce SHALL be 1 for JMP, ~N for JGE and ~Z for JNE.
REQ-028 EXEC, F=7 (STP): no enables asserted; go to HALT.
REQ-029 EXEC, F=8..15: no enables asserted; go to FAULT.
REQ-030 HALT: Halted=1; FAULT: Fault=1.
REQ-031 HALT and FAULT SHALL assert no enables or memory requests and are left only by reset.
REQ-032 A 4-bit wait counter SHALL increment each cycle a memory request is asserted with MEM_ready=0.
REQ-033 The wait counter SHALL clear on every state transition and on any cycle with MEM_ready=1.
REQ-034 When the wait counter equals TIMEOUT with MEM_ready=0, the next state SHALL be FAULT and all enables SHALL stay 0 in that cycle.
REQ-035 MEM_ready=1 in the same cycle the counter reaches TIMEOUT SHALL complete the access normally; ready takes priority over timeout.
REQ-036 MEM_ready SHALL be ignored in HALT and FAULT and in EXEC for F>=4.
REQ-037 A fetch-execute cycle with zero-wait memory SHALL take exactly 2 clocks.

Reset
REQ-038 nReset=0 SHALL asynchronously force state=FETCH and wait counter=0 regardless of Clk, including mid-access.
REQ-039 With nReset=0, all outputs SHALL take their FETCH/MEM_ready=0 values: MEM_rd=1, X_sel=1, ALU_fs=10, all other outputs 0.
REQ-040 The first rising Clk edge after nReset deasserts SHALL evaluate FETCH normally.

Verification
REQ-041 Reset, then F=0 with MEM_ready held 1 -> FETCH (IR_ce=PC_ce=1), then EXEC with Addr_sel=1 and Acc_ce=1, then FETCH; 2 clocks per instruction.
REQ-042 F=5, N=1 in EXEC -> PC_ce=0; repeat with N=0 -> PC_ce=1 and Y_sel=1, ALU_fs=00; likewise F=6 against Z.
REQ-043 F=1, MEM_ready=0 for 3 cycles then 1 -> MEM_wr=1 and Acc_oe=1 for 4 cycles, then FETCH; no enable asserted at any point.
REQ-044 Default TIMEOUT, MEM_ready held 0 in FETCH -> Fault=1 after the timeout cycle; repeat with ready=1 exactly on the timeout cycle -> normal EXEC entry.
REQ-045 F=7 -> Halted=1 and stays set while MEM_ready and F toggle; F=9 -> Fault=1; nReset pulse (asynchronous, mid-cycle) -> immediate FETCH outputs.
